// File: rtl/gf283_pkg.sv
// Shared constants, state encoding and helpers for the GF(2^283) reduction
// stage. The field polynomial is f(x) = x^283 + x^12 + x^7 + x^5 + 1.
package gf283_pkg;

    // Field degree and width of the unreduced carry-less product
    localparam int M  = 283;
    localparam int PW = 2 * M - 1;

    // Default number of product bits folded per cycle
    localparam int W_DEFAULT = 47;

    // Width of the running degree bound (must hold PW-1 = 564)
    localparam int HI_W = 10;

    // Low-order taps of the pentanomial: x^283 == x^0 + x^5 + x^7 + x^12
    localparam int TAP_N = 4;
    localparam int TAPS [TAP_N] = '{0, 5, 7, 12};

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // Number of fold cycles needed to bring the degree bound below M
    function automatic int num_folds(input int w);
        return (M - 1 + w - 1) / w;
    endfunction

    // Fold cycles for the default chunk width (6 for W = 47)
    localparam int N = num_folds(W_DEFAULT);

endpackage

// File: rtl/gf283_fold_step.sv
// One combinational fold of the product accumulator: the chunk of bits
// [max(M, hi-W+1) .. hi] is cleared and re-injected at x^(k), x^(k+5),
// x^(k+7), x^(k+12) for every set coefficient x^(M+k). Also reports whether
// everything from bit M up to hi is already zero, so the sequencer can skip
// work when the early-exit build is selected.
module gf283_fold_step
    import gf283_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [PW-1:0]   acc_i,
    input  logic [HI_W-1:0] hi_i,
    output logic [PW-1:0]   acc_o,
    output logic [HI_W-1:0] hi_o,
    output logic            last_o,
    output logic            upper_zero_o
);

    int            hi_int;
    int            lo_int;
    logic [PW-1:0] chunk_mask;
    logic [PW-1:0] upper_mask;
    logic [PW-1:0] chunk;
    logic [PW-1:0] high;

    // Build the bit masks for the current chunk window and for the whole
    // still-unreduced region above the field degree.
    always_comb begin
        hi_int     = int'(hi_i);
        lo_int     = hi_int - W + 1;
        chunk_mask = '0;
        upper_mask = '0;
        if (lo_int < M) begin
            lo_int = M;
        end
        for (int p = 0; p < PW; p++) begin
            chunk_mask[p] = (p >= lo_int) && (p <= hi_int);
            upper_mask[p] = (p >= M) && (p <= hi_int);
        end
    end

    // Clear the chunk and XOR it back in, shifted down by M, once per tap.
    // With W <= M-12 the highest re-injected bit lands below the next window.
    always_comb begin
        chunk = acc_i & chunk_mask;
        high  = chunk >> M;
        acc_o = acc_i & ~chunk_mask;
        for (int t = 0; t < TAP_N; t++) begin
            acc_o = acc_o ^ (high << TAPS[t]);
        end
    end

    // Advance the degree bound and flag the final fold.
    always_comb begin
        hi_o         = hi_i - HI_W'(W);
        last_o       = (hi_o < HI_W'(M));
        upper_zero_o = ((acc_i & upper_mask) == '0);
    end

endmodule

// File: rtl/gf283_reduce.sv
// Sequential reduction of a 565-bit carry-less product modulo the NIST B-283
// pentanomial. Accepts one product in IDLE, folds W bits per cycle in FOLD,
// and presents the 283-bit result in DONE over a valid/ready handshake.
// Optional build macro GF283_REDUCE_EARLY_EXIT_EN: when defined, a FOLD cycle
// whose remaining high part is all zero jumps straight to DONE.
module gf283_reduce
    import gf283_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_res
);

    localparam logic [HI_W-1:0] HI_START = HI_W'(PW - 1);

`ifdef GF283_REDUCE_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    gf_state_e       state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic            out_valid_q, out_valid_d;
    logic [M-1:0]    out_res_q, out_res_d;

    logic [PW-1:0]   fold_acc;
    logic [HI_W-1:0] fold_hi;
    logic            fold_last;
    logic            upper_zero;

    gf283_fold_step #(
        .W (W)
    ) u_fold (
        .acc_i        (acc_q),
        .hi_i         (hi_q),
        .acc_o        (fold_acc),
        .hi_o         (fold_hi),
        .last_o       (fold_last),
        .upper_zero_o (upper_zero)
    );

    // Next-state logic: accept in IDLE, fold until the degree bound drops
    // below M, then hold the registered result until the consumer takes it.
    // The first DONE cycle loads the output register, so out_valid rises one
    // edge after the last fold.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_prod;
                    hi_d    = HI_START;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                if (EARLY_EXIT && upper_zero) begin
                    state_d = DONE;
                end else begin
                    acc_d = fold_acc;
                    hi_d  = fold_hi;
                    if (fold_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_res_d   = acc_q[M-1:0];
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;

endmodule

// File: tb/tb_gf283_reduce.sv
// Self-checking bench for gf283_reduce: directed products with known results
// and latencies, output back-pressure, mid-fold reset, and a random run of
// carry-less products compared against a bit-serial mod-f model.
module tb_gf283_reduce;

    localparam int LAT_FULL = gf283_pkg::N + 1;
`ifdef GF283_REDUCE_EARLY_EXIT_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = LAT_FULL;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [564:0] in_prod;
    logic         out_valid;
    logic         out_ready;
    logic [282:0] out_res;

    int           err_count = 0;
    int           check_count = 0;
    logic [282:0] exp_q [$];
    logic [282:0] mon_exp;
    bit           rand_ready = 1'b0;

    gf283_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it
    task automatic checkOutput(input string tag, input logic [564:0] actual,
                               input logic [564:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reduction: clear the top set coefficient and add back f(x)
    function automatic logic [282:0] refReduce(input logic [564:0] p);
        logic [564:0] r;
        r = p;
        for (int i = 564; i >= 283; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i - 283] = ~r[i - 283];
                r[i - 278] = ~r[i - 278];
                r[i - 276] = ~r[i - 276];
                r[i - 271] = ~r[i - 271];
            end
        end
        return r[282:0];
    endfunction

    // Carry-less product of two field elements (unreduced)
    function automatic logic [564:0] clmul(input logic [282:0] a, input logic [282:0] b);
        logic [564:0] r;
        r = '0;
        for (int i = 0; i < 283; i++) begin
            if (b[i]) r = r ^ (565'(a) << i);
        end
        return r;
    endfunction

    function automatic logic [282:0] rand283();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom;
        return t[282:0];
    endfunction

    // Offer a product, wait for acceptance, and optionally log its result
    task automatic applyStimulus(input logic [564:0] prod, input logic [282:0] expected,
                                 input bit do_push);
        int wait_cyc;
        wait_cyc = 0;
        in_prod  = prod;
        in_valid = 1'b1;
        while (!in_ready && wait_cyc < 200) begin
            tick();
            wait_cyc++;
        end
        if (!in_ready) checkOutput("accept_timeout", 565'(in_ready), 565'(1));
        tick();
        if (do_push) exp_q.push_back(expected);
        in_valid = 1'b0;
        in_prod  = ~prod;
    endtask

    task automatic waitOutput(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        checkOutput("out_valid_timeout", 565'(out_valid), 565'(1));
    endtask

    // Scoreboard: every output handshake pops and compares one expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checkOutput("sb_nonempty", 565'(exp_q.size() != 0), 565'(1));
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("out_res", 565'(out_res), 565'(mon_exp));
            end
        end
    end

    // Random consumer back-pressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int           lat;
        int           drain;
        logic [564:0] p283;
        logic [564:0] p564;
        logic [282:0] e283;
        logic [282:0] e564;
        logic [282:0] a;
        logic [282:0] b;
        logic [564:0] prod;

        p283 = 565'd1 << 283;
        p564 = 565'd1 << 564;
        e283 = 283'h10A1;
        e564 = (283'd1 << 281) | 283'h401528;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_in_ready", 565'(in_ready), 565'(1));
        checkOutput("rst_out_valid", 565'(out_valid), 565'(0));
        checkOutput("rst_out_res", 565'(out_res), 565'(0));
        rst = 1'b0;
        tick();

        $display("[TB] directed: x^283");
        out_ready = 1'b1;
        applyStimulus(p283, e283, 1'b1);
        waitOutput(lat);
        checkOutput("lat_x283", 565'(lat), 565'(LAT_FULL));
        tick();
        checkOutput("post_hs_out_valid", 565'(out_valid), 565'(0));
        checkOutput("post_hs_in_ready", 565'(in_ready), 565'(1));

        $display("[TB] directed: x^564");
        applyStimulus(p564, e564, 1'b1);
        waitOutput(lat);
        checkOutput("lat_x564", 565'(lat), 565'(LAT_FULL));
        tick();

        $display("[TB] directed: low-only product");
        applyStimulus(565'h1234, 283'h1234, 1'b1);
        waitOutput(lat);
        checkOutput("lat_low", 565'(lat), 565'(LAT_SHORT));
        tick();

        $display("[TB] back-pressure hold in DONE");
        out_ready = 1'b0;
        applyStimulus(p564, e564, 1'b1);
        waitOutput(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_prod  = clmul(rand283(), rand283());
            checkOutput("hold_out_valid", 565'(out_valid), 565'(1));
            checkOutput("hold_out_res", 565'(out_res), 565'(e564));
            checkOutput("hold_in_ready", 565'(in_ready), 565'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("hold_release_out_valid", 565'(out_valid), 565'(0));
        checkOutput("hold_release_in_ready", 565'(in_ready), 565'(1));

        $display("[TB] reset during third fold cycle");
        applyStimulus(p283, e283, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort_in_ready", 565'(in_ready), 565'(1));
        checkOutput("abort_out_valid", 565'(out_valid), 565'(0));
        rst = 1'b0;
        applyStimulus(p283, e283, 1'b1);
        waitOutput(lat);
        checkOutput("lat_after_abort", 565'(lat), 565'(LAT_FULL));
        tick();

        $display("[TB] random products with random out_ready");
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a    = rand283();
            b    = rand283();
            prod = clmul(a, b);
            applyStimulus(prod, refReduce(prod), 1'b1);
        end
        drain = 0;
        while (exp_q.size() != 0 && drain < 1000) begin
            tick();
            drain++;
        end
        checkOutput("drain_empty", 565'(exp_q.size()), 565'(0));
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/gf283_reduce.md
# gf283_reduce

Sequential modular-reduction stage for GF(2^283) multiplication. Sits directly downstream of the 283-bit overlap-free Karatsuba multiplier and consumes its 565-bit unreduced carry-less product. Folds the product modulo the NIST B-283 pentanomial f(x) = x^283 + x^12 + x^7 + x^5 + 1 over a fixed number of cycles. Returns the 283-bit field element over a valid/ready handshake.

## Interface
- M, 283, field degree; product width is 2*M-1 = 565
- W, 47, bits folded per cycle; legal range 1..271
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_prod is valid
- in_ready  output  1  block can accept a product
- in_prod  input  2*M-1  unreduced product, bit i = coefficient of x^i
- out_valid  output  1  out_res is valid
- out_ready  input  1  consumer accepts out_res
- out_res  output  M  reduced result, bit i = coefficient of x^i

## Operation
- States: IDLE, FOLD, DONE. Internal registers: acc (2*M-1 bits), hi (degree bound, 10 bits).
- IDLE: in_ready=1. When in_valid&&in_ready: acc<=in_prod, hi<=2*M-2 (564), go to FOLD.
- FOLD: in_ready=0. Chunk = acc bits [max(M, hi-W+1) : hi]. Clear those bits. XOR the chunk back in at bit offsets -M, -M+5, -M+7 and -M+12 (x^(M+k) -> x^k + x^(k+5) + x^(k+7) + x^(k+12)). Set hi <= hi-W.
  - If the new hi < M, go to DONE.
  - With W <= 271, re-injected bits stay below the new chunk window, so no bit is ever lost.
- Number of FOLD cycles is N = ceil((M-1)/W); N = 6 for W=47.
- DONE: out_valid=1, out_res=acc[M-1:0].
  - out_res is held stable while out_ready=0.
  - On out_ready=1, go to IDLE.
- No overlap: a new product is accepted only in IDLE, so there is at most one operation in flight.
- Arithmetic is pure GF(2): XOR only, no carries.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_res=0, acc=0.
- rst asserted mid-FOLD or in DONE aborts the operation. The next cycle is IDLE with out_valid=0, and the result is discarded.
- Input handshake at edge k gives FOLD during cycles k+1..k+N. out_valid rises after edge k+N+1; for W=47 that is 7 cycles after accept.
- Output handshake at edge j: out_valid=0 and in_ready=1 from edge j. The next accept is possible at edge j+1.
- in_prod is sampled only on the accept edge. Changes to it afterwards are ignored.
- in_valid asserted while in_ready=0 has no effect. The upstream stage holds its data.

## Configuration
- GF283_REDUCE_EARLY_EXIT_EN
  - Defined: in each FOLD cycle, if acc[hi:M] is all zero, go straight to DONE without folding. A product with zero high part reaches out_valid 2 cycles after accept. Latency varies from 2 to N+1.
  - Undefined: always exactly N FOLD cycles; fixed latency N+1.
- Both builds give the same out_res for every input.

## Structure
- Package gf283_pkg holds:
  - M
  - default W
  - pentanomial tap offsets {0,5,7,12}
  - the state enum (IDLE/FOLD/DONE)
  - the derived constant N
- Sub-module gf283_fold_step: combinational, one fold of a W-bit chunk into acc given hi. This keeps the FSM/handshake separate from the XOR network.

## Test plan
- in_prod = x^283 (bit 283 only) -> out_res = 0x10A1 (bits 0,5,7,12); out_valid exactly 7 cycles after accept with early exit undefined.
- in_prod = x^564 -> out_res bits {281,22,12,10,8,5,3} set, all others 0.
- in_prod = 0x1234 (high part zero) -> out_res = 0x1234; latency 7 cycles, or 2 cycles with GF283_REDUCE_EARLY_EXIT_EN.
- Hold out_ready=0 for 10 cycles in DONE -> out_res and out_valid stable, in_ready=0; in_valid pulses are ignored.
- Assert rst on the 3rd FOLD cycle -> next cycle in_ready=1, out_valid=0; a following x^283 input still yields 0x10A1.
- Run 1000 random back-to-back products through the Karatsuba multiplier plus this block with random out_ready -> every out_res matches a bit-serial golden mod-f model.
